// File: rtl/vram_pkg.sv
// Shared constants and types for the UltraRAM frame-buffer scheduler.
package vram_pkg;

    localparam int VRAM_ADDR_WIDTH   = 14;
    localparam int VRAM_WORDS        = 12288;
    localparam int VRAM_READ_LATENCY = 3;

    typedef enum logic {
        RD_SCAN = 1'b0,
        RD_HOST = 1'b1
    } vram_rd_id_t;

    typedef struct packed {
        logic        valid;
        vram_rd_id_t id;
    } vram_rd_tag_t;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_CLEAR = 1'b1
    } vram_wr_state_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Tracks which client owns each in-flight RAM read and steers the RAM
// output to that client's response port when the data arrives.
module vram_rd_tag_pipe #(
    parameter int READ_LATENCY = vram_pkg::VRAM_READ_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        grant,
    input  logic        grant_host,
    input  logic [63:0] ram_douta,
    output logic        scan_rsp_valid,
    output logic [63:0] scan_rsp_data,
    output logic        host_rsp_valid,
    output logic [63:0] host_rsp_data
);
    import vram_pkg::*;

    vram_rd_tag_t tags [READ_LATENCY];
    vram_rd_tag_t tail;

    // NOTE: the tag array is reset, unlike a data RAM: a stale valid bit here
    // would emit a phantom response. Sequential state uses <= so every stage
    // samples the previous stage's old value on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= '{valid: grant, id: (grant_host ? RD_HOST : RD_SCAN)};
            for (int i = 1; i < READ_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    assign tail           = tags[READ_LATENCY-1];
    assign scan_rsp_valid = tail.valid && (tail.id == RD_SCAN);
    assign host_rsp_valid = tail.valid && (tail.id == RD_HOST);
    assign scan_rsp_data  = scan_rsp_valid ? ram_douta : '0;
    assign host_rsp_data  = host_rsp_valid ? ram_douta : '0;

endmodule

// File: rtl/vram_scheduler.sv
// Front end of the UltraRAM frame buffer: scan/host read arbitration with a
// starvation guard, and a write port shared by the pixel writer and a clear engine.
module vram_scheduler #(
    parameter int ADDR_WIDTH   = vram_pkg::VRAM_ADDR_WIDTH,
    parameter int VRAM_WORDS   = vram_pkg::VRAM_WORDS,
    parameter int READ_LATENCY = vram_pkg::VRAM_READ_LATENCY,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start,
    input  logic [63:0]           clear_value,
    output logic                  clear_busy,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [63:0]           wr_data,
    input  logic [7:0]            wr_strb,
    input  logic                  scan_req_valid,
    output logic                  scan_req_ready,
    input  logic [ADDR_WIDTH-1:0] scan_req_addr,
    output logic                  scan_rsp_valid,
    output logic [63:0]           scan_rsp_data,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic [ADDR_WIDTH-1:0] host_req_addr,
    output logic                  host_rsp_valid,
    output logic [63:0]           host_rsp_data,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic                  ram_ena,
    input  logic [63:0]           ram_douta,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic [7:0]            ram_web,
    output logic [63:0]           ram_dinb
);
    import vram_pkg::*;

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(VRAM_WORDS - 1);

    vram_wr_state_t        state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [63:0]           clr_value;
    logic [STARVE_W-1:0]   starve_cnt;

    logic wr_fire;
    logic scan_elig, host_elig, host_pri;
    logic scan_grant, host_grant;

    // ---------------- write port: pixel writer / clear engine ----------------
    assign clear_busy = (state == WR_CLEAR);
    assign wr_ready   = rst_n && (state == WR_IDLE);
    assign wr_fire    = wr_valid && wr_ready;

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        ram_enb   = 1'b0;
        ram_addrb = '0;
        ram_web   = '0;
        ram_dinb  = '0;
        if (clear_busy) begin
            ram_enb   = 1'b1;
            ram_addrb = clr_cnt;
            ram_web   = 8'hFF;
            ram_dinb  = clr_value;
        end else if (wr_fire) begin
            ram_enb   = 1'b1;
            ram_addrb = wr_addr;
            ram_web   = wr_strb;
            ram_dinb  = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WR_IDLE;
            clr_cnt   <= '0;
            clr_value <= '0;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (clear_start) begin
                        state     <= WR_CLEAR;
                        clr_value <= clear_value;
                        clr_cnt   <= '0;
                    end
                end
                WR_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state   <= WR_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

    // ---------------- read port arbitration ----------------
    // Scan normally wins; once the host has watched STARVE_LIMIT scan grants
    // in a row it takes the next contested cycle.
    assign scan_elig  = rst_n && scan_req_valid;
    assign host_elig  = rst_n && host_req_valid && !clear_busy;
    assign host_pri   = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
    assign host_grant = host_elig && (!scan_elig || host_pri);
    assign scan_grant = scan_elig && !host_grant;

    assign scan_req_ready = scan_grant;
    assign host_req_ready = host_grant;
    assign ram_ena        = scan_grant || host_grant;
    assign ram_addra      = host_grant ? host_req_addr :
                            scan_grant ? scan_req_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (host_grant || !host_req_valid) begin
            starve_cnt <= '0;
        end else if (scan_grant && !host_pri) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    vram_rd_tag_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tag_pipe (
        .clk            (clk),
        .rst_n          (rst_n),
        .grant          (ram_ena),
        .grant_host     (host_grant),
        .ram_douta      (ram_douta),
        .scan_rsp_valid (scan_rsp_valid),
        .scan_rsp_data  (scan_rsp_data),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_data  (host_rsp_data)
    );

endmodule

// File: tb/tb_vram_scheduler.sv
// Self-checking bench for vram_scheduler: a table of single-cycle arbitration
// vectors plus directed sequences for latency, starvation, clear and reset.
module tb_vram_scheduler;

    localparam int AW = 14;
    localparam int W  = 12288;
    localparam logic [63:0] M100 = 64'hDEAD_BEEF_0000_0064;
    localparam logic [63:0] M200 = 64'hDEAD_BEEF_0000_00C8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_start;
    logic [63:0]   clear_value;
    logic          clear_busy;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic [7:0]    wr_strb;
    logic          scan_req_valid, scan_req_ready;
    logic [AW-1:0] scan_req_addr;
    logic          scan_rsp_valid;
    logic [63:0]   scan_rsp_data;
    logic          host_req_valid, host_req_ready;
    logic [AW-1:0] host_req_addr;
    logic          host_rsp_valid;
    logic [63:0]   host_rsp_data;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic          ram_ena, ram_enb;
    logic [63:0]   ram_douta = '0;
    logic [7:0]    ram_web;
    logic [63:0]   ram_dinb;

    vram_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_start    (clear_start),
        .clear_value    (clear_value),
        .clear_busy     (clear_busy),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_strb        (wr_strb),
        .scan_req_valid (scan_req_valid),
        .scan_req_ready (scan_req_ready),
        .scan_req_addr  (scan_req_addr),
        .scan_rsp_valid (scan_rsp_valid),
        .scan_rsp_data  (scan_rsp_data),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_req_addr  (host_req_addr),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_data  (host_rsp_data),
        .ram_addra      (ram_addra),
        .ram_ena        (ram_ena),
        .ram_douta      (ram_douta),
        .ram_addrb      (ram_addrb),
        .ram_enb        (ram_enb),
        .ram_web        (ram_web),
        .ram_dinb       (ram_dinb)
    );

    always #5 clk = ~clk;

    // Behavioural UltraRAM: 3-cycle read latency, byte-enabled write.
    logic [63:0]   mem [0:W-1];
    logic [AW-1:0] rd_a1 = '0;
    logic [AW-1:0] rd_a2 = '0;

    always @(posedge clk) begin
        rd_a1     <= ram_addra;
        rd_a2     <= rd_a1;
        ram_douta <= mem[rd_a2];
        if (ram_enb) begin
            for (int b = 0; b < 8; b++) begin
                if (ram_web[b]) mem[ram_addrb][b*8 +: 8] <= ram_dinb[b*8 +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_start    = 1'b0;
        clear_value    = '0;
        wr_valid       = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        wr_strb        = '0;
        scan_req_valid = 1'b0;
        scan_req_addr  = '0;
        host_req_valid = 1'b0;
        host_req_addr  = '0;
    endtask

    function automatic logic [40:0] pk(input logic wr_r, input logic enb, input logic [7:0] web,
                                       input logic sr, input logic hr, input logic ena,
                                       input logic [AW-1:0] aa, input logic [AW-1:0] ab);
        return {wr_r, enb, web, sr, hr, ena, aa, ab};
    endfunction

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [63:0]   wd;
        logic [7:0]    ws;
        logic          sv;
        logic [AW-1:0] sa;
        logic          hv;
        logic [AW-1:0] ha;
        logic [40:0]   exp_ctl;
        logic [63:0]   exp_dinb;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int   busy_cnt, bad_cnt, scan_ok;
    logic exp_h, exp_hr, exp_sr;

    initial begin
        vecs[0] = '{1'b1, 14'd5, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0, 14'd0, 1'b0, 14'd0,
                    pk(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 14'd0, 14'd5), 64'h0123_4567_89AB_CDEF};
        vecs[1] = '{1'b0, 14'd0, 64'h0, 8'h00, 1'b1, 14'd10, 1'b0, 14'd0,
                    pk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 14'd10, 14'd0), 64'h0};
        vecs[2] = '{1'b0, 14'd0, 64'h0, 8'h00, 1'b0, 14'd0, 1'b1, 14'd20,
                    pk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 14'd20, 14'd0), 64'h0};
        vecs[3] = '{1'b0, 14'd0, 64'h0, 8'h00, 1'b1, 14'd30, 1'b1, 14'd40,
                    pk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 14'd30, 14'd0), 64'h0};
        vecs[4] = '{1'b0, 14'd0, 64'h0, 8'h00, 1'b0, 14'd0, 1'b1, 14'd41,
                    pk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 14'd41, 14'd0), 64'h0};
        vecs[5] = '{1'b1, 14'd7, 64'h1111_2222_3333_4444, 8'hFF, 1'b1, 14'd8, 1'b0, 14'd0,
                    pk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 14'd8, 14'd7), 64'h1111_2222_3333_4444};
        vecs[6] = '{1'b0, 14'd0, 64'h0, 8'h00, 1'b0, 14'd0, 1'b0, 14'd0,
                    pk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0), 64'h0};

        for (int i = 0; i < W; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);

        // ---- reset values ----
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", 128'({wr_ready, clear_busy, scan_req_ready, host_req_ready, scan_rsp_valid,
                                 host_rsp_valid, ram_ena, ram_enb, ram_web, ram_addra, ram_addrb}), 128'(0));
        check("reset_data", 128'(scan_rsp_data | host_rsp_data | ram_dinb), 128'(0));
        next();
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_after_reset", 128'(wr_ready), 128'(1));
        next();

        // ---- table-driven single-cycle vectors ----
        for (int i = 0; i < NV; i++) begin
            wr_valid       = vecs[i].wv;
            wr_addr        = vecs[i].wa;
            wr_data        = vecs[i].wd;
            wr_strb        = vecs[i].ws;
            scan_req_valid = vecs[i].sv;
            scan_req_addr  = vecs[i].sa;
            host_req_valid = vecs[i].hv;
            host_req_addr  = vecs[i].ha;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i),
                  128'({wr_ready, ram_enb, ram_web, scan_req_ready, host_req_ready, ram_ena, ram_addra, ram_addrb}),
                  128'(vecs[i].exp_ctl));
            check($sformatf("vec%0d_dinb", i), 128'(ram_dinb), 128'(vecs[i].exp_dinb));
            next();
        end
        idle_inputs();
        repeat (4) next();

        // ---- read latency and back-to-back scan/host ----
        scan_req_valid = 1'b1;
        scan_req_addr  = 14'd5;
        @(negedge clk);
        check("rdA_scan_grant", 128'(scan_req_ready), 128'(1));
        next();
        scan_req_valid = 1'b0;
        host_req_valid = 1'b1;
        host_req_addr  = 14'd7;
        @(negedge clk);
        check("rdA_t1", 128'({host_req_ready, scan_rsp_valid, host_rsp_valid}), 128'(3'b100));
        next();
        host_req_valid = 1'b0;
        @(negedge clk);
        check("rdA_t2", 128'({scan_rsp_valid, host_rsp_valid}), 128'(2'b00));
        next();
        @(negedge clk);
        check("rdA_t3_valid", 128'({scan_rsp_valid, host_rsp_valid}), 128'(2'b10));
        check("rdA_t3_data", 128'({scan_rsp_data, host_rsp_data}), {64'hDEAD_BEEF_89AB_CDEF, 64'h0});
        next();
        @(negedge clk);
        check("rdA_t4_valid", 128'({scan_rsp_valid, host_rsp_valid}), 128'(2'b01));
        check("rdA_t4_data", 128'({scan_rsp_data, host_rsp_data}), {64'h0, 64'h1111_2222_3333_4444});
        next();
        repeat (4) next();

        // ---- starvation guard: scan and host both always valid ----
        scan_req_valid = 1'b1;
        scan_req_addr  = 14'd100;
        host_req_valid = 1'b1;
        host_req_addr  = 14'd200;
        for (int i = 0; i < 48; i++) begin
            exp_h  = (i % 16 == 15);
            exp_hr = (i >= 3) && ((i - 3) % 16 == 15);
            exp_sr = (i >= 3) && !exp_hr;
            @(negedge clk);
            check($sformatf("starve_c%0d_flags", i),
                  128'({scan_req_ready, host_req_ready, scan_rsp_valid, host_rsp_valid}),
                  128'({!exp_h, exp_h, exp_sr, exp_hr}));
            check($sformatf("starve_c%0d_data", i), {scan_rsp_data, host_rsp_data},
                  {(exp_sr ? M100 : 64'h0), (exp_hr ? M200 : 64'h0)});
            next();
        end
        idle_inputs();
        repeat (4) next();

        // ---- clear, with a held write, a host request, scans and a second start ----
        clear_start = 1'b1;
        clear_value = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("clr_start_cycle", 128'({clear_busy, wr_ready, ram_enb}), 128'(3'b010));
        next();
        clear_value    = '0;
        wr_valid       = 1'b1;
        wr_addr        = 14'd9;
        wr_data        = 64'h5555_AAAA_5555_AAAA;
        wr_strb        = 8'hFF;
        host_req_valid = 1'b1;
        host_req_addr  = 14'd300;
        busy_cnt = 0;
        bad_cnt  = 0;
        scan_ok  = 0;
        for (int i = 1; i <= W; i++) begin
            clear_start    = (i == 5);
            scan_req_valid = (i <= 8);
            scan_req_addr  = 14'd301;
            @(negedge clk);
            if (clear_busy) busy_cnt++;
            if (!(ram_enb && ram_addrb == 14'(i - 1) && ram_web == 8'hFF &&
                  ram_dinb == 64'hFFFF_FFFF_FFFF_FFFF && !wr_ready && !host_req_ready)) bad_cnt++;
            if (i <= 8 && scan_req_ready && ram_ena && ram_addra == 14'd301) scan_ok++;
            next();
        end
        clear_start    = 1'b0;
        scan_req_valid = 1'b0;
        check("clr_busy_cycles", 128'(busy_cnt), 128'(W));
        check("clr_write_seq", 128'(bad_cnt), 128'(0));
        check("clr_scan_grants", 128'(scan_ok), 128'(8));
        @(negedge clk);
        check("clr_done", 128'({clear_busy, wr_ready, ram_enb, ram_addrb, host_req_ready, ram_addra}),
              128'({1'b0, 1'b1, 1'b1, 14'd9, 1'b1, 14'd300}));
        check("clr_done_dinb", 128'(ram_dinb), 128'(64'h5555_AAAA_5555_AAAA));
        next();
        wr_valid       = 1'b0;
        host_req_valid = 1'b0;
        next();
        next();
        @(negedge clk);
        check("clr_host_rsp", 128'({host_rsp_valid, host_rsp_data}), 128'({1'b1, 64'hFFFF_FFFF_FFFF_FFFF}));
        next();

        scan_req_valid = 1'b1;
        scan_req_addr  = 14'd9;
        next();
        scan_req_addr  = 14'd5;
        next();
        scan_req_valid = 1'b0;
        next();
        @(negedge clk);
        check("post_clr_rd9", 128'({scan_rsp_valid, scan_rsp_data}), 128'({1'b1, 64'h5555_AAAA_5555_AAAA}));
        next();
        @(negedge clk);
        check("post_clr_rd5", 128'({scan_rsp_valid, scan_rsp_data}), 128'({1'b1, 64'hFFFF_FFFF_FFFF_FFFF}));
        next();
        repeat (3) next();

        // ---- reset mid-flight: two grants in flight plus a running clear ----
        clear_start    = 1'b1;
        clear_value    = 64'h1234;
        scan_req_valid = 1'b1;
        scan_req_addr  = 14'd1;
        @(negedge clk);
        check("rstmid_grant0", 128'(scan_req_ready), 128'(1));
        next();
        clear_start   = 1'b0;
        scan_req_addr = 14'd2;
        @(negedge clk);
        check("rstmid_grant1", 128'({scan_req_ready, clear_busy}), 128'(2'b11));
        next();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_in_reset", 128'({wr_ready, clear_busy, scan_rsp_valid, host_rsp_valid, ram_ena, ram_enb}),
              128'(0));
        next();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rstmid_after%0d", i),
                  128'({scan_rsp_valid, host_rsp_valid, clear_busy, wr_ready, ram_enb}), 128'(5'b00010));
            next();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
